// File: rtl/l4_fetch_unit.sv
// l4_fetch_unit
// Instruction-supply side of the lab 4 processor. It holds the program store,
// the program counter and the instruction register. It answers the control
// FSM's pc_en/ILin requests with decoded instruction fields.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   pc_en, ILin       advance PC / latch IR (from the control FSM)
//   prog_valid/_data  loader word handshake; prog_ready = word accepted if valid
//   start, clear      (re)start execution at address 0 / discard program
//   operation,rx,ry,imm  instruction register fields
//   pc                current program counter (AW+1 bits, saturates at prog_len)
//   halted, overrun   HALT state flag; sticky fetch-past-end flag
module l4_fetch_unit #(
    parameter  int RA_W  = 2,
    parameter  int IMM_W = 4,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int IW    = 3 + 2*RA_W + IMM_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_en,
    input  logic             ILin,
    input  logic             prog_valid,
    input  logic [IW-1:0]    prog_data,
    output logic             prog_ready,
    input  logic             start,
    input  logic             clear,
    output logic [2:0]       operation,
    output logic [RA_W-1:0]  rx,
    output logic [RA_W-1:0]  ry,
    output logic [IMM_W-1:0] imm,
    output logic [AW:0]      pc,
    output logic             halted,
    output logic             overrun
);

    localparam logic [2:0]    OP_HALT   = 3'b101;
    localparam logic [IW-1:0] HALT_WORD = {OP_HALT, {(IW-3){1'b0}}};
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_PROG, S_RUN, S_HALT} state_t;

    state_t          r_state, w_state_nxt;
    logic [AW:0]     r_wr_ptr, w_wr_ptr_nxt;
    logic [AW:0]     r_prog_len, w_prog_len_nxt;
    logic [AW:0]     r_pc, w_pc_nxt;
    logic [IW-1:0]   r_ir, w_ir_nxt;
    logic            r_overrun, w_overrun_nxt;
    // Set when a HALT word has just been latched; HALT is entered one edge
    // later. A flag is used instead of decoding IR so that a restart from
    // HALT (which keeps the HALT word in IR) does not immediately re-halt.
    logic            r_halt_pend, w_halt_pend_nxt;

    logic [IW-1:0]   r_mem [DEPTH];

    logic            w_in_range;
    logic [IW-1:0]   w_fetch_word;
    logic            w_accept;
    logic [AW:0]     w_count;

    assign w_in_range   = (r_pc < r_prog_len);
    assign w_fetch_word = w_in_range ? r_mem[r_pc[AW-1:0]] : HALT_WORD;

    assign prog_ready   = (r_state == S_PROG) && (r_wr_ptr < DEPTH_C);
    // clear discards the store, so a word offered alongside it is dropped.
    assign w_accept     = prog_ready && prog_valid && !clear;
    // Word count seen by start includes a word accepted in the same cycle.
    assign w_count      = r_wr_ptr + {{AW{1'b0}}, w_accept};

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_prog_len_nxt  = r_prog_len;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_overrun_nxt   = r_overrun;
        w_halt_pend_nxt = r_halt_pend;

        case (r_state)
            S_PROG: begin
                if (clear) begin
                    w_wr_ptr_nxt   = '0;
                    w_prog_len_nxt = '0;
                end else begin
                    if (w_accept) begin
                        w_wr_ptr_nxt = w_count;
                    end
                    if (start && (w_count != '0)) begin
                        w_prog_len_nxt  = w_count;
                        w_pc_nxt        = '0;
                        w_overrun_nxt   = 1'b0;
                        w_halt_pend_nxt = 1'b0;
                        w_state_nxt     = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (clear) begin
                    w_wr_ptr_nxt    = '0;
                    w_prog_len_nxt  = '0;
                    w_halt_pend_nxt = 1'b0;
                    w_state_nxt     = S_PROG;
                end else if (r_halt_pend) begin
                    w_halt_pend_nxt = 1'b0;
                    w_state_nxt     = S_HALT;
                end else begin
                    // With pc_en and ILin together, IR takes the word at the old pc.
                    if (ILin) begin
                        w_ir_nxt = w_fetch_word;
                        if (!w_in_range) begin
                            w_overrun_nxt = 1'b1;
                        end
                        if (w_fetch_word[IW-1 -: 3] == OP_HALT) begin
                            w_halt_pend_nxt = 1'b1;
                        end
                    end
                    if (pc_en && w_in_range) begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (clear) begin
                    w_wr_ptr_nxt   = '0;
                    w_prog_len_nxt = '0;
                    w_state_nxt    = S_PROG;
                end else if (start) begin
                    w_pc_nxt      = '0;
                    w_overrun_nxt = 1'b0;
                    w_state_nxt   = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_PROG;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_PROG;
            r_wr_ptr    <= '0;
            r_prog_len  <= '0;
            r_pc        <= '0;
            r_ir        <= '0;
            r_overrun   <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_prog_len  <= w_prog_len_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_overrun   <= w_overrun_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

    // Program store contents survive reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= prog_data;
        end
    end

    assign operation = r_ir[IW-1 -: 3];
    assign rx        = r_ir[IW-4 -: RA_W];
    assign ry        = r_ir[IW-4-RA_W -: RA_W];
    assign imm       = r_ir[IMM_W-1:0];
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_l4_fetch_unit.sv
module tb_l4_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_en, ILin, prog_valid, start, clear;
    logic [10:0] prog_data;
    logic        prog_ready;
    logic [2:0]  operation;
    logic [1:0]  rx, ry;
    logic [3:0]  imm;
    logic [4:0]  pc;
    logic        halted, overrun;

    int n_total = 0;
    int n_pass  = 0;

    l4_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .ILin(ILin),
        .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
        .start(start), .clear(clear), .operation(operation), .rx(rx), .ry(ry),
        .imm(imm), .pc(pc), .halted(halted), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rs;
        bit          pe, il, st, cl, pv;
        logic [10:0] pd;
        logic [10:0] ir;
        logic [4:0]  epc;
        bit          h, ov, rdy;
        string       nm;
    } vec_t;

    typedef struct {
        logic [10:0] ir;
        logic [4:0]  epc;
        bit          h, ov, rdy;
        string       nm;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    localparam logic [10:0] W0 = 11'b000_01_00_0101;
    localparam logic [10:0] W1 = 11'b011_10_01_0000;
    localparam logic [10:0] W2 = 11'b101_00_00_0000;
    localparam logic [10:0] A0 = 11'b001_11_10_1010;
    localparam logic [10:0] A1 = 11'b010_00_11_0011;

    function automatic vec_t mk(input bit rs, pe, il, st, cl, pv,
                                input logic [10:0] pd, ir, input logic [4:0] epc,
                                input bit h, ov, rdy, input string nm);
        vec_t v;
        v = '{rs, pe, il, st, cl, pv, pd, ir, epc, h, ov, rdy, nm};
        return v;
    endfunction

    function automatic logic [10:0] word(input int c);
        logic [7:0] b;
        b = 8'(c * 13 + 5);
        return {3'b010, b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic idle_inputs();
        pc_en = 0; ILin = 0; start = 0; clear = 0; prog_valid = 0; prog_data = '0;
    endtask

    // Asynchronous pulse placed between clock edges.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        if (v.rs) do_reset();
        pc_en = v.pe; ILin = v.il; start = v.st; clear = v.cl;
        prog_valid = v.pv; prog_data = v.pd;
        exp_q.push_back('{v.ir, v.epc, v.h, v.ov, v.rdy, v.nm});
        @(posedge clk); #1;
        idle_inputs();
        e = exp_q.pop_front();
        chk({e.nm, ".ir"},  32'({operation, rx, ry, imm}), 32'(e.ir));
        chk({e.nm, ".pc"},  32'(pc),         32'(e.epc));
        chk({e.nm, ".hlt"}, 32'(halted),     32'(e.h));
        chk({e.nm, ".ovr"}, 32'(overrun),    32'(e.ov));
        chk({e.nm, ".rdy"}, 32'(prog_ready), 32'(e.rdy));
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        int acc;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.op",  32'(operation), 0);
        chk("rst.pc",  32'(pc), 0);
        chk("rst.rdy", 32'(prog_ready), 1);
        chk("rst.hlt", 32'(halted), 0);
        reset = 1'b0;

        //                rs pe il st cl pv pd   ir  pc h ov rdy
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, W0, '0, 0, 0, 0, 1, "s1.ld0"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, W1, '0, 0, 0, 0, 1, "s1.ld1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, W2, '0, 0, 0, 0, 1, "s1.ld2"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, '0, '0, 0, 0, 0, 0, "s1.start"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W0, 1, 0, 0, 0, "s1.f1"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0, W0, 1, 0, 0, 0, "s1.i1"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W1, 2, 0, 0, 0, "s1.f2"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0, W1, 2, 0, 0, 0, "s1.i2"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W2, 3, 0, 0, 0, "s1.f3"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0, W2, 3, 1, 0, 0, "s1.i3"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W2, 3, 1, 0, 0, "h.fetchign"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, '0, W2, 0, 0, 0, 0, "h.restart"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W0, 1, 0, 0, 0, "r.f1"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W1, 2, 0, 0, 0, "r.f2"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W2, 3, 0, 0, 0, "r.f3"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0, W2, 3, 1, 0, 0, "r.i3"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, '0, W2, 3, 0, 0, 1, "h.clr_st"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, '0, W2, 3, 0, 0, 1, "p.st_empty"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, A0, W2, 0, 0, 0, 0, "p.ld_st"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0, A0, 0, 0, 0, 0, "il.only1"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0, A0, 0, 0, 0, 0, "il.only2"));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, '0, A0, 1, 0, 0, 0, "pe.only"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, '0, W2, 1, 0, 1, 0, "il.past"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0, W2, 1, 1, 1, 0, "il.halt"));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, A0, '0, 0, 0, 0, 1, "s3.ld0"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, A1, '0, 0, 0, 0, 1, "s3.ld1"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, '0, '0, 0, 0, 0, 0, "s3.start"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, A0, 1, 0, 0, 0, "s3.f1"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, A1, 2, 0, 0, 0, "s3.f2"));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, '0, W2, 2, 0, 1, 0, "s3.f3"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, '0, W2, 2, 1, 1, 0, "s3.idle"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, '0, W2, 0, 0, 0, 0, "s3.restart"));

        foreach (vecs[i]) apply(vecs[i]);

        // Loader saturation: valid held for 20 cycles after reset.
        do_reset();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            prog_valid = 1'b1;
            prog_data  = word(c);
            chk($sformatf("ld.rdy%0d", c), 32'(prog_ready), (c < 16) ? 1 : 0);
            if (prog_ready) acc++;
            @(posedge clk); #1;
        end
        idle_inputs();
        chk("ld.count", acc, 16);
        start = 1'b1; step();
        chk("ld.run_rdy", 32'(prog_ready), 0);
        ILin = 1'b1; step();
        chk("ld.mem0", 32'({operation, rx, ry, imm}), 32'(word(0)));
        chk("ld.mem0_pc", 32'(pc), 0);
        pc_en = 1'b1; step();
        chk("ld.pe_pc", 32'(pc), 1);
        chk("ld.pe_ir", 32'({operation, rx, ry, imm}), 32'(word(0)));
        ILin = 1'b1; step();
        chk("ld.mem1", 32'({operation, rx, ry, imm}), 32'(word(1)));

        // Asynchronous reset in the middle of the second fetch.
        do_reset();
        prog_valid = 1'b1; prog_data = W0; step();
        prog_valid = 1'b1; prog_data = W1; step();
        prog_valid = 1'b1; prog_data = W2; step();
        start = 1'b1; step();
        pc_en = 1'b1; ILin = 1'b1; step();
        chk("ar.pre_op", 32'(operation), 0);
        chk("ar.pre_pc", 32'(pc), 1);
        pc_en = 1'b1; ILin = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("ar.fields", 32'({operation, rx, ry, imm}), 0);
        chk("ar.pc",     32'(pc), 0);
        chk("ar.hlt",    32'(halted), 0);
        chk("ar.ovr",    32'(overrun), 0);
        chk("ar.rdy",    32'(prog_ready), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_inputs();
        start = 1'b1; step();
        chk("ar.st_ign_rdy", 32'(prog_ready), 1);
        chk("ar.st_ign_pc",  32'(pc), 0);
        pc_en = 1'b1; ILin = 1'b1; step();
        chk("ar.f_ign_op", 32'(operation), 0);
        chk("ar.f_ign_pc", 32'(pc), 0);
        prog_valid = 1'b1; prog_data = W1; start = 1'b1; step();
        chk("ar.run_rdy", 32'(prog_ready), 0);
        pc_en = 1'b1; ILin = 1'b1; step();
        chk("ar.run_op", 32'(operation), 3);
        chk("ar.run_pc", 32'(pc), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
